// File: rtl/ir_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO, updated on the falling
// clock edge, with flush, empty-queue bypass and a sticky overflow flag.
module ir_queue #(
  parameter int DATA_W      = 32,
  parameter int IMM_W       = 8,
  parameter int DEPTH       = 4,
  parameter int BBUS_SIGNED = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          im_out,
  input  logic                       im_r,
  input  logic                       ir_load,
  input  logic                       flush,
  output logic [DATA_W-1:0]          abus_in,
  output logic [DATA_W-1:0]          bbus_in,
  output logic                       ir_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] ir;
  logic              valid_q;
  logic              ovf_q;

  logic pop;
  logic bypass;
  logic push;
  logic drop;

  always_comb begin
    empty  = (cnt == '0);
    full   = (cnt == CNT_W'(DEPTH));
    pop    = ir_load && !empty;
    bypass = ir_load && im_r && empty;
    // A bypassed word goes straight to the IR and never occupies a queue slot.
    push   = im_r && !bypass && (!full || pop);
    drop   = im_r && full && !pop;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ir      <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ir      <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= im_out;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        ir      <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
        valid_q <= 1'b1;
      end else if (bypass) begin
        ir      <= im_out;
        valid_q <= 1'b1;
      end else if (ir_load) begin
        valid_q <= 1'b0;
      end
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign abus_in  = ir;
  assign ir_valid = valid_q;
  assign count    = cnt;
  assign overflow = ovf_q;

  generate
    if (IMM_W < DATA_W) begin : g_ext
      assign bbus_in = {{(DATA_W-IMM_W){(BBUS_SIGNED != 0) & ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    end else begin : g_full
      assign bbus_in = ir;
    end
  endgenerate

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the points called out by the test plan.
module tb_ir_queue;

  localparam int DW   = 32;
  localparam int DEP  = 4;
  localparam int SGN  = 1;

  logic          clock;
  logic          reset;
  logic [DW-1:0] im_out;
  logic          im_r;
  logic          ir_load;
  logic          flush;
  logic [DW-1:0] abus_in;
  logic [DW-1:0] bbus_in;
  logic          ir_valid;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  ir_queue #(.DATA_W(DW), .IMM_W(8), .DEPTH(DEP), .BBUS_SIGNED(SGN)) dut (
    .clock(clock), .reset(reset), .im_out(im_out), .im_r(im_r), .ir_load(ir_load),
    .flush(flush), .abus_in(abus_in), .bbus_in(bbus_in), .ir_valid(ir_valid),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  // Reference model: a plain queue of pending words plus the IR.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_ir;
  logic          m_valid;
  logic          m_ovf;

  always @(negedge clock or posedge reset) begin
    if (reset || flush) begin
      q.delete();
      m_ir    = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      automatic bit took = 1'b0;
      if (ir_load) begin
        if (q.size() > 0) begin
          m_ir    = q.pop_front();
          m_valid = 1'b1;
        end else if (im_r) begin
          m_ir    = im_out;
          m_valid = 1'b1;
          took    = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (im_r && !took) begin
        if (q.size() < DEP) q.push_back(im_out);
        else                m_ovf = 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] ext_imm(input logic [DW-1:0] w);
    logic [7:0] b;
    b = w[7:0];
    if (SGN != 0) return DW'($signed(b));
    return {24'h0, b};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active (falling) edge.
  always @(posedge clock) begin
    chk("m_abus",  abus_in, m_ir);
    chk("m_bbus",  bbus_in, ext_imm(m_ir));
    chk("m_valid", DW'(ir_valid), DW'(m_valid));
    chk("m_count", DW'(count), DW'(q.size()));
    chk("m_full",  DW'(full), DW'(q.size() == DEP));
    chk("m_empty", DW'(empty), DW'(q.size() == 0));
    chk("m_ovf",   DW'(overflow), DW'(m_ovf));
  end

  task automatic step(input logic r, input logic ld, input logic fl, input logic [DW-1:0] d);
    im_r    = r;
    ir_load = ld;
    flush   = fl;
    im_out  = d;
    @(negedge clock);
    #1;
    im_r    = 1'b0;
    ir_load = 1'b0;
    flush   = 1'b0;
    im_out  = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abus"},  abus_in, 32'h0);
    chk({tag, "_bbus"},  bbus_in, 32'h0);
    chk({tag, "_valid"}, DW'(ir_valid), 32'd0);
    chk({tag, "_count"}, DW'(count), 32'd0);
    chk({tag, "_empty"}, DW'(empty), 32'd1);
    chk({tag, "_full"},  DW'(full), 32'd0);
    chk({tag, "_ovf"},   DW'(overflow), 32'd0);
  endtask

  logic [DW-1:0] rw [4];
  logic [DW-1:0] sw [8];

  initial begin
    reset = 1'b1; im_r = 1'b0; ir_load = 1'b0; flush = 1'b0; im_out = '0;
    #2;
    chk_reset_vals("rst");
    #6 reset = 1'b0;

    // Push then load one word; immediate 0xF3 sign-extends.
    step(1, 0, 0, 32'hA5A5_00F3);
    chk("t1_count1", DW'(count), 32'd1);
    step(0, 1, 0, '0);
    chk("t1_abus",  abus_in, 32'hA5A5_00F3);
    chk("t1_bbus",  bbus_in, 32'hFFFF_FFF3);
    chk("t1_valid", DW'(ir_valid), 32'd1);
    chk("t1_count", DW'(count), 32'd0);

    // Five pushes into a 4-deep queue: the fifth is dropped.
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 32'h0000_0100 + DW'(i));
      if (i == 4) chk("t2_full4", DW'(full), 32'd1);
    end
    chk("t2_ovf",   DW'(overflow), 32'd1);
    chk("t2_count", DW'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, '0);
      chk("t2_order", abus_in, 32'h0000_0100 + DW'(i));
    end
    chk("t2_empty", DW'(empty), 32'd1);

    // Refill, then stream push+load for 8 edges across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      rw[i] = 32'hBEEF_0000 + DW'(i);
      step(1, 0, 0, rw[i]);
    end
    for (int j = 0; j < 8; j++) begin
      sw[j] = 32'h5000_0000 + DW'(j * 17);
      step(1, 1, 0, sw[j]);
      chk("t3_count", DW'(count), 32'd4);
      chk("t3_abus",  abus_in, (j < 4) ? rw[j] : sw[j-4]);
    end
    chk("t3_ovf_sticky", DW'(overflow), 32'd1);
    step(0, 0, 1, '0);
    chk("t3_flush_ovf",   DW'(overflow), 32'd0);
    chk("t3_flush_count", DW'(count), 32'd0);

    // Bypass from empty, then bubble.
    step(1, 1, 0, 32'h1234_5678);
    chk("t4_abus",  abus_in, 32'h1234_5678);
    chk("t4_count", DW'(count), 32'd0);
    chk("t4_valid", DW'(ir_valid), 32'd1);
    step(0, 1, 0, '0);
    chk("t4_bubble_valid", DW'(ir_valid), 32'd0);
    chk("t4_bubble_abus",  abus_in, 32'h1234_5678);

    // Overflow, pop to 3 queued, then flush with concurrent push and load.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h7700_0000 + DW'(i));
    step(0, 1, 0, '0);
    chk("t5_pre_count", DW'(count), 32'd3);
    chk("t5_pre_ovf",   DW'(overflow), 32'd1);
    step(1, 1, 1, 32'hDEAD_BEEF);
    chk("t5_count", DW'(count), 32'd0);
    chk("t5_valid", DW'(ir_valid), 32'd0);
    chk("t5_abus",  abus_in, 32'h0);
    chk("t5_ovf",   DW'(overflow), 32'd0);
    step(0, 1, 0, '0);
    chk("t5_absent_abus",  abus_in, 32'h0);
    chk("t5_absent_valid", DW'(ir_valid), 32'd0);

    // Asynchronous reset between edges with two queued words.
    step(1, 0, 0, 32'h0BAD_0001);
    step(1, 1, 0, 32'h0BAD_0002);
    step(1, 0, 0, 32'h0BAD_0003);
    chk("t6_pre_count", DW'(count), 32'd2);
    #1 reset = 1'b1;
    #1 chk_reset_vals("arst");
    #1 reset = 1'b0;
    step(1, 0, 0, 32'hCAFE_F00D);
    step(0, 1, 0, '0);
    chk("t6_abus",  abus_in, 32'hCAFE_F00D);
    chk("t6_count", DW'(count), 32'd0);
    step(0, 1, 0, '0);
    chk("t6_only_new", DW'(ir_valid), 32'd0);

    step(0, 0, 0, '0);
    @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with an integrated prefetch queue for the downsampling processor datapath. Instruction words from instruction memory (`im_out`) are buffered in a DEPTH-entry FIFO and advanced into the instruction register on demand. The register drives the full word onto the A bus and an extended immediate field onto the B bus. Flush, fall-through bypass and overflow detection are added so the fetch stage can run ahead of decode and be squashed on branches.

## Interface
- DATA_W, 32, instruction word width
- IMM_W, 8, immediate field width; occupies IR[IMM_W-1:0]; 1 ≤ IMM_W ≤ DATA_W
- DEPTH, 4, prefetch FIFO entries; power of two, ≥ 2
- BBUS_SIGNED, 0, 0 = zero-extend immediate onto `bbus_in`, 1 = sign-extend

- clock  in  1  single clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- im_out  in  DATA_W  instruction word from instruction memory
- im_r  in  1  push request: write `im_out` into the queue
- ir_load  in  1  advance: move the queue head into the IR
- flush  in  1  discard all queued words and invalidate the IR
- abus_in  out  DATA_W  IR contents
- bbus_in  out  DATA_W  IR[IMM_W-1:0], extended per BBUS_SIGNED
- ir_valid  out  1  IR holds a live instruction
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  queued words, excluding the IR
- overflow  out  1  sticky: a push was dropped

## Operation
- Storage is a circular buffer with a write pointer, a read pointer and a count, plus the IR register.
- Push is accepted when `im_r` is high and either `!full`, or `full` with a simultaneous accepted pop.
- If `im_r` is high while `full` and there is no pop, the word is dropped and `overflow` is set to 1.
- Pop occurs when `ir_load` is high and `!empty`: the head word goes to the IR, `ir_valid` becomes 1, and the read pointer advances.
- Bypass: `ir_load` and `im_r` high together while `empty` loads `im_out` directly into the IR. `ir_valid` becomes 1 and `count` stays 0.
- Bubble: `ir_load` high while `empty` with no `im_r` leaves the IR data held and sets `ir_valid` to 0.
- `ir_load` low: the IR and `ir_valid` hold.
- Push and pop on the same edge with count > 0: `count` is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush has priority over push, pop and bypass on the same edge. It does the following:
  - `count` = 0 and both pointers = 0;
  - IR = 0 and `ir_valid` = 0;
  - `overflow` = 0;
  - a concurrent `im_r` word is discarded.
- Output rules:
  - `abus_in` = IR;
  - `bbus_in` = {(DATA_W-IMM_W){BBUS_SIGNED & IR[IMM_W-1]}, IR[IMM_W-1:0]};
  - `full`, `empty` and `bbus_in` are combinational from registered state.

## Timing
- Reset (asynchronous, takes effect immediately) sets:
  - IR = 0, so `abus_in` = 0 and `bbus_in` = 0;
  - `ir_valid` = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0;
  - pointers = 0.
- Reset asserted mid-operation abandons queued words with no partial update. The first falling edge after deassertion behaves as from the empty state.
- Push latency: a word pushed at falling edge k is visible in `count` after edge k. It can reach the IR at edge k+1 at the earliest.
- Bypass latency: the word is on `abus_in` immediately after the edge that samples it.
- Inputs must be stable around the falling edge. Outputs change only after the falling edge or on reset.
- Throughput: one push and one pop per cycle; a full queue sustains continuous streaming with no dropped words.

## Test plan
- Reset, then push 0xA5A5_00F3 at one edge and pulse `ir_load` at the next -> `abus_in` = 0xA5A5_00F3, `bbus_in` = 0x0000_00F3 (BBUS_SIGNED=0) or 0xFFFF_FFF3 (BBUS_SIGNED=1), `ir_valid` = 1, `count` = 0.
- Push 5 words with DEPTH=4 and no loads -> `full` = 1 after the 4th push, 5th word dropped, `overflow` = 1. Then 4 loads -> IR takes words 1..4 in order, then `empty` = 1.
- With `full`, assert `im_r` and `ir_load` for 8 edges -> no drops, `count` stays 4, IR sequence exactly matches push order across pointer wrap.
- From empty, assert `im_r` = 1 and `ir_load` = 1 with `im_out` = 0x1234_5678 -> IR = 0x1234_5678 after one edge, `count` = 0. Next edge, `ir_load` alone -> `ir_valid` = 0, `abus_in` still 0x1234_5678.
- With 3 queued words, assert `flush` together with `im_r` and `ir_load` -> `count` = 0, `ir_valid` = 0, `abus_in` = 0, `overflow` = 0, pushed word absent.
- Assert `reset` asynchronously between edges with 2 queued words -> all outputs immediately at reset values. The next push followed by a load delivers the new word only.
